// File: rtl/clb_cfg_pkg.sv
// Shared widths, constants and loader state encoding for the CLB configuration loader.
package clb_cfg_pkg;
    localparam int IC_W      = 6;
    localparam int LUT_W     = 16;
    localparam int FF_W      = 3;
    localparam int OC_W      = 2;
    localparam int CLB_CFG_W = IC_W + LUT_W + FF_W + OC_W;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY         = 8'h07;

    typedef enum logic [1:0] {SYNC, LOAD, CHECK, COMMIT} loader_state_e;
endpackage

// File: rtl/clb_config_loader_if.sv
// 1-bit valid/ready configuration bitstream link between programming port and loader.
interface clb_config_loader_if;
    logic cfg_bit;
    logic cfg_valid;
    logic cfg_ready;

    modport master (output cfg_bit, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_bit, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/clb_config_loader_crc8.sv
// Serial MSB-first CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
module crc8_serial
    import clb_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);
    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear)
            crc_d = '0;
        else if (en)
            crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_in) ? CRC8_POLY : 8'h00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/clb_config_loader.sv
// Sync-hunting serial loader that deserializes NUM_CLBS frames and commits them atomically.
// Optional CRC-8 payload check is enabled with `define CLB_CFG_CRC_EN.
module clb_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int         NUM_CLBS  = 4,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    clb_config_loader_if.slave         cfg,
    output logic [IC_W*NUM_CLBS-1:0]   input_configuration_word,
    output logic [LUT_W*NUM_CLBS-1:0]  lut_configuration_word,
    output logic [FF_W*NUM_CLBS-1:0]   flip_flop_configuration_word,
    output logic [OC_W*NUM_CLBS-1:0]   output_configuration_word,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);
    localparam int W     = CLB_CFG_W * NUM_CLBS;
    localparam int CNT_W = $clog2(W + 1);

    loader_state_e              state_q;
    logic [7:0]                 sr_q, sr_d;
    logic [W-1:0]               shadow_q, shadow_d, commit_src;
    logic [CNT_W-1:0]           bit_cnt_q;
    logic [IC_W*NUM_CLBS-1:0]   ic_q, ic_d;
    logic [LUT_W*NUM_CLBS-1:0]  lut_q, lut_d;
    logic [FF_W*NUM_CLBS-1:0]   ff_q, ff_d;
    logic [OC_W*NUM_CLBS-1:0]   oc_q, oc_d;
    logic                       done_q;
    logic                       accept, sync_hit, last_payload, commit_en;

    assign cfg.cfg_ready = (state_q != COMMIT);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign sr_d          = {sr_q[6:0], cfg.cfg_bit};
    assign shadow_d      = {shadow_q[W-2:0], cfg.cfg_bit};
    assign sync_hit      = accept && (state_q == SYNC) && (sr_d == SYNC_WORD);
    assign last_payload  = accept && (state_q == LOAD) && (bit_cnt_q == CNT_W'(W - 1));

`ifdef CLB_CFG_CRC_EN
    logic [7:0] crc_w;
    logic       error_q;
    logic       crc_last;

    crc8_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (sync_hit),
        .en     (accept && (state_q == LOAD)),
        .bit_in (cfg.cfg_bit),
        .crc    (crc_w)
    );

    assign crc_last  = accept && (state_q == CHECK) && (bit_cnt_q == CNT_W'(7));
    assign commit_en = crc_last && (sr_d == crc_w);
    assign error     = error_q;
`else
    assign commit_en = last_payload;
    assign error     = 1'b0;
`endif

    // Committing straight out of LOAD must include the bit arriving this cycle.
    assign commit_src = (state_q == LOAD) ? shadow_d : shadow_q;

    always_comb begin
        logic [CLB_CFG_W-1:0] frame;
        ic_d  = '0;
        lut_d = '0;
        ff_d  = '0;
        oc_d  = '0;
        frame = '0;
        for (int k = 0; k < NUM_CLBS; k++) begin
            frame = commit_src[W-1-CLB_CFG_W*k -: CLB_CFG_W];
            ic_d[IC_W*k +: IC_W]    = frame[IC_W-1:0];
            lut_d[LUT_W*k +: LUT_W] = frame[IC_W+LUT_W-1:IC_W];
            ff_d[FF_W*k +: FF_W]    = frame[IC_W+LUT_W+FF_W-1:IC_W+LUT_W];
            oc_d[OC_W*k +: OC_W]    = frame[CLB_CFG_W-1:IC_W+LUT_W+FF_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SYNC;
            sr_q      <= '0;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            ic_q      <= '0;
            lut_q     <= '0;
            ff_q      <= '0;
            oc_q      <= '0;
            done_q    <= 1'b0;
`ifdef CLB_CFG_CRC_EN
            error_q   <= 1'b0;
`endif
        end else begin
            done_q <= commit_en;
            if (commit_en) begin
                ic_q    <= ic_d;
                lut_q   <= lut_d;
                ff_q    <= ff_d;
                oc_q    <= oc_d;
                state_q <= COMMIT;
            end
            case (state_q)
                SYNC: if (accept) begin
                    sr_q <= sr_d;
                    if (sync_hit) begin
                        // sr is cleared so a stale sync word cannot re-trigger later.
                        state_q   <= LOAD;
                        bit_cnt_q <= '0;
                        sr_q      <= '0;
`ifdef CLB_CFG_CRC_EN
                        error_q   <= 1'b0;
`endif
                    end
                end
                LOAD: if (accept) begin
                    shadow_q  <= shadow_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef CLB_CFG_CRC_EN
                    if (last_payload) begin
                        state_q   <= CHECK;
                        bit_cnt_q <= '0;
                    end
`endif
                end
`ifdef CLB_CFG_CRC_EN
                CHECK: if (accept) begin
                    sr_q      <= sr_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (crc_last) begin
                        sr_q <= '0;
                        if (!commit_en) begin
                            error_q <= 1'b1;
                            state_q <= SYNC;
                        end
                    end
                end
`endif
                COMMIT:  state_q <= SYNC;
                default: state_q <= SYNC;
            endcase
        end
    end

    assign input_configuration_word     = ic_q;
    assign lut_configuration_word       = lut_q;
    assign flip_flop_configuration_word = ff_q;
    assign output_configuration_word    = oc_q;
    assign busy                         = (state_q != SYNC);
    assign done                         = done_q;
endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader with NUM_CLBS=2; CRC cases run when CLB_CFG_CRC_EN is defined.
module tb_clb_config_loader;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ic;
    logic [31:0] lut;
    logic [5:0]  ff;
    logic [3:0]  oc;
    logic        busy, done, error;
    int          n_chk = 0;
    int          n_err = 0;

    // Hand-packed frames: {CLB0, CLB1}, each {oc, ff, lut, ic}.
    logic [53:0] frame_a = {2'b10, 3'b011, 16'hBEEF, 6'b101010, 2'b00, 3'b000, 16'h8001, 6'b000000};
    logic [53:0] frame_b = {2'b01, 3'b100, 16'h1234, 6'b000111, 2'b11, 3'b111, 16'hA5A5, 6'b111000};

    clb_config_loader_if cfg_if ();

    clb_config_loader #(.NUM_CLBS(N), .SYNC_WORD(8'hA5)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .cfg                          (cfg_if),
        .input_configuration_word     (ic),
        .lut_configuration_word       (lut),
        .flip_flop_configuration_word (ff),
        .output_configuration_word    (oc),
        .busy                         (busy),
        .done                         (done),
        .error                        (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_cfg(input string tag, input logic [11:0] e_ic, input logic [31:0] e_lut,
                           input logic [5:0] e_ff, input logic [3:0] e_oc);
        chk({tag, "_ic"}, 32'(ic), 32'(e_ic));
        chk({tag, "_lut"}, lut, e_lut);
        chk({tag, "_ff"}, 32'(ff), 32'(e_ff));
        chk({tag, "_oc"}, 32'(oc), 32'(e_oc));
    endtask

    // Drives one bit from a falling edge; it is consumed on the next rising edge with ready high.
    task automatic send_bit(input logic b, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            @(negedge clk);
            cfg_if.cfg_valid = 1'b0;
        end
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = b;
            if (cfg_if.cfg_ready) return;
        end
        chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

`ifdef CLB_CFG_CRC_EN
    function automatic logic [7:0] crc8(input logic [53:0] p);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 53; i >= 0; i--)
            c = {c[6:0], 1'b0} ^ ((c[7] ^ p[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    task automatic send_frame(input logic [53:0] p, input bit gaps, input bit bad_crc);
        logic [7:0] c;
        send_byte(8'hA5, gaps);
        for (int i = 53; i >= 0; i--) send_bit(p[i], gaps);
`ifdef CLB_CFG_CRC_EN
        c = crc8(p) ^ (bad_crc ? 8'h10 : 8'h00);
        send_byte(c, gaps);
`else
        c = {7'd0, bad_crc};
`endif
    endtask

    initial begin
        reset            = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_bit   = 1'b0;
        repeat (3) @(negedge clk);
        chk_cfg("rst", 12'h000, 32'h0, 6'h00, 4'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        chk("rst_busy2", 32'(busy), 32'd0);

        // Nominal frame A, no gaps: done and outputs one cycle after the last bit.
        send_frame(frame_a, 1'b0, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("a_done", 32'(done), 32'd1);
        chk_cfg("a", 12'h02A, 32'h8001_BEEF, 6'h03, 4'h2);
        @(negedge clk);
        chk("a_done_low", 32'(done), 32'd0);
        chk("a_busy_low", 32'(busy), 32'd0);

        // Reset after 20 payload bits of frame B, then a full frame B.
        send_byte(8'hA5, 1'b0);
        for (int i = 53; i >= 34; i--) send_bit(frame_b[i], 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_cfg("mid_rst", 12'h000, 32'h0, 6'h00, 4'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send_frame(frame_b, 1'b0, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("b_done", 32'(done), 32'd1);
        chk_cfg("b", 12'hE07, 32'hA5A5_1234, 6'h3C, 4'hD);

        // Garbage 5A then frame A with random valid gaps.
        send_byte(8'h5A, 1'b1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("garbage_busy", 32'(busy), 32'd0);
        send_frame(frame_a, 1'b1, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("gap_done", 32'(done), 32'd1);
        chk_cfg("gap", 12'h02A, 32'h8001_BEEF, 6'h03, 4'h2);

        // Back-to-back: B then A offered immediately; ready drops only in COMMIT.
        send_frame(frame_b, 1'b0, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_bit   = 1'b1;
        chk("b2b_ready_commit", 32'(cfg_if.cfg_ready), 32'd0);
        chk("b2b_done1", 32'(done), 32'd1);
        chk_cfg("b2b_b", 12'hE07, 32'hA5A5_1234, 6'h3C, 4'h4 + 4'h9);
        send_frame(frame_a, 1'b0, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("b2b_done2", 32'(done), 32'd1);
        chk_cfg("b2b_a", 12'h02A, 32'h8001_BEEF, 6'h03, 4'h2);

`ifdef CLB_CFG_CRC_EN
        // Corrupted CRC: no commit, sticky error; next good frame clears it.
        send_frame(frame_b, 1'b0, 1'b1);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("crc_bad_done", 32'(done), 32'd0);
        chk("crc_bad_error", 32'(error), 32'd1);
        chk("crc_bad_busy", 32'(busy), 32'd0);
        chk_cfg("crc_bad", 12'h02A, 32'h8001_BEEF, 6'h03, 4'h2);
        repeat (3) @(negedge clk);
        chk("crc_sticky", 32'(error), 32'd1);
        send_frame(frame_b, 1'b0, 1'b0);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        chk("crc_good_done", 32'(done), 32'd1);
        chk("crc_good_error", 32'(error), 32'd0);
        chk_cfg("crc_good", 12'hE07, 32'hA5A5_1234, 6'h3C, 4'hD);
`else
        chk("no_crc_error", 32'(error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/clb_config_loader.md
Name: clb_config_loader

Overview:
- Serial configuration writer for the CLB array.
- Hunts for a sync word on a 1-bit handshaked bitstream and deserializes NUM_CLBS per-CLB frames into a shadow register.
- On frame completion, commits atomically to the active input/LUT/flip-flop/output configuration buses that drive the CLBs.
- Sits between the off-chip programming port and the CLB tile array.

Parameters:
- NUM_CLBS, 4, number of CLBs configured per frame; CLB 0 is transmitted first.
- SYNC_WORD, 8'hA5, pattern marking frame start, MSB first.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cfg_bit  in  1  serial bitstream data
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_ready  out  1  loader accepts a bit this cycle; transfer occurs when cfg_valid && cfg_ready
- input_configuration_word  out  6*NUM_CLBS  per-CLB input mux selects; CLB k at [6k+5:6k]
- lut_configuration_word  out  16*NUM_CLBS  per-CLB LUT masks; CLB k at [16k+15:16k]
- flip_flop_configuration_word  out  3*NUM_CLBS  per-CLB flip-flop config
- output_configuration_word  out  2*NUM_CLBS  per-CLB output mux selects
- busy  out  1  high in LOAD/CHECK/COMMIT
- done  out  1  one-cycle pulse when the active config updates
- error  out  1  sticky CRC failure flag (only with CLB_CFG_CRC_EN; tied 0 otherwise)

Behaviour:
- Frame layout per CLB: 27 bits, MSB first = {output[1:0], ff[2:0], lut[15:0], input[5:0]}.
- Payload W = 27*NUM_CLBS bits, CLB 0 first; shifted left into shadow, so CLB 0 ends at shadow[W-1 -: 27].
- Reset (async assert, sync release): all config outputs 0, shadow 0, busy=0, done=0, error=0, state=SYNC, counters 0.
- A mid-load reset discards the partial frame; active config returns to 0.
- FSM states:
  - SYNC: cfg_ready=1. An 8-bit shift register captures each accepted bit. When {sr[6:0], cfg_bit} == SYNC_WORD on an accepted bit, go to LOAD next cycle and clear bit_cnt. Overlapping patterns are detected. Entry into LOAD clears error.
  - LOAD: cfg_ready=1. Each accepted bit shifts into shadow; bit_cnt increments. Width is $clog2(W+1). The bit accepted with bit_cnt == W-1 exits to CHECK (macro on) or COMMIT (macro off). Sync patterns inside the payload are data, not resync.
  - CHECK: cfg_ready=1. Accepts 8 CRC bits, MSB first. Match → COMMIT. Mismatch → error=1, back to SYNC, active config unchanged.
  - COMMIT: cfg_ready=0 for exactly one cycle. Active outputs <= shadow slices; done=1 that cycle; next state SYNC.
- Accepted-bit-to-done latency:
  - Macro off: last payload bit accepted in cycle N → outputs update and done=1 at edge N+1 (visible in cycle N+1).
  - Macro on: same timing, measured from the last CRC bit.
- cfg_valid low stalls any state without losing progress. Bits are never consumed while cfg_ready=0.
- Active outputs change only in COMMIT; the CLBs never see a partial frame.
- busy = (state != SYNC).

Optional Feature:
- Macro CLB_CFG_CRC_EN.
- Defined:
  - CHECK state present.
  - Serial CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, computed over the W payload bits only (not the sync word).
  - error is a sticky register.
- Undefined:
  - LOAD goes directly to COMMIT; no CRC logic.
  - error tied to 0.

Decomposition:
- Package clb_cfg_pkg holds:
  - widths IC_W=6, LUT_W=16, FF_W=3, OC_W=2, CLB_CFG_W=27;
  - SYNC_WORD_DEFAULT 8'hA5 and CRC8_POLY 8'h07;
  - loader state enum {SYNC, LOAD, CHECK, COMMIT}.
- One sub-module, crc8_serial (clk, reset, clear, en, bit_in, crc[7:0]), instantiated only under CLB_CFG_CRC_EN.

Test Plan:
- Reset values: NUM_CLBS=2, deassert reset → all config buses 0, cfg_ready=1, busy=0, done=0.
- Nominal load, macro off: send A5, then CLB0 = {2'b10, 3'b011, 16'hBEEF, 6'b101010}, CLB1 = all-zero except lut 16'h8001.
  - lut_configuration_word = 32'h8001_BEEF; input[5:0] = 6'b101010; output[1:0] = 2'b10.
  - done pulses exactly one cycle after the last bit.
- Stalls and overlap: random cfg_valid gaps (~50% duty) plus a preceding garbage stream 8'h5A,8'hA5 embedded → same outputs as the no-gap run; sync found at the first complete A5.
- Reset mid-load: assert reset after 20 payload bits → outputs 0, state SYNC. A fresh full frame then loads correctly.
- CRC pass/fail (macro on): correct CRC → done=1, error=0. Flip one CRC bit → no done, outputs keep the previous frame, error=1. Next good frame clears error upon sync.
- Back-to-back frames: second frame starts the cycle after COMMIT. cfg_ready=0 only during the COMMIT cycle; no bit lost or duplicated.
